// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Contents: the operand, product and step-counter widths, and the sequencer state type.
// Build option: MULT_ZERO_SKIP_EN. When it is defined, a start with a zero operand
// skips the RUN phase.
package mult_pkg;

  localparam int unsigned MULT_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage : mult_pkg

// File: rtl/mult_row_step.sv
// One add step of the multiplier. It adds the multiplicand, gated by the current
// multiplier bit, to the upper half of the accumulator. The logic is purely
// combinational.
// Ports:
//   acc_hi : upper half of the accumulator
//   A      : multiplicand
//   b_bit  : multiplier bit for this step
//   sum    : 16-bit sum
//   carry  : carry out of the 17-bit add
module mult_row_step
  import mult_pkg::*;
(
  input  logic [MULT_W-1:0] acc_hi,
  input  logic [MULT_W-1:0] A,
  input  logic              b_bit,
  output logic [MULT_W-1:0] sum,
  output logic              carry
);

  logic [MULT_W-1:0] addend;

  assign addend         = b_bit ? A : '0;
  assign {carry, sum}   = (MULT_W+1)'(acc_hi) + (MULT_W+1)'(addend);

endmodule : mult_row_step

// File: rtl/mult_sequencer.sv
// Sequential unsigned 16x16 multiplier. It processes one bit of B per cycle, LSB first.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : multiply request, accepted in IDLE or DONE
//   A, B         : operands, captured when start is accepted
//   busy         : high during the 16 RUN cycles
//   done         : one-cycle completion pulse
//   product      : registered result, held until the next completion
// Build option: MULT_ZERO_SKIP_EN. When it is defined, a zero operand goes straight to DONE.
module mult_sequencer
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MULT_W-1:0] A,
  input  logic [MULT_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  stateT             state;
  stateT             nextState;
  logic [MULT_W-1:0] aReg;
  logic [MULT_W-1:0] bReg;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] accNext;
  logic [CNT_W-1:0]  stepCnt;
  logic              accept;
  logic              zeroOp;
  logic              lastStep;
  logic              busyNext;
  logic              doneNext;
  logic              loadProduct;
  logic              clearProduct;
  logic [MULT_W-1:0] rowSum;
  logic              rowCarry;

  // Add/shift datapath for the current step
  mult_row_step uRowStep (
    .acc_hi (acc[PROD_W-1:MULT_W]),
    .A      (aReg),
    .b_bit  (bReg[stepCnt]),
    .sum    (rowSum),
    .carry  (rowCarry)
  );

  // The whole {carry, acc} register shifts right by one. The low bit that falls
  // off is already final.
  assign accNext  = {rowCarry, rowSum, acc[MULT_W-1:1]};
  assign lastStep = (stepCnt == CNT_W'(MULT_W-1));

`ifdef MULT_ZERO_SKIP_EN
  assign zeroOp = (A == '0) || (B == '0);
`else
  assign zeroOp = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        nextState = IDLE;
        if (start) begin
          accept    = 1'b1;
          nextState = zeroOp ? DONE : RUN;
        end
      end
      RUN: begin
        if (lastStep) nextState = DONE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Output decode. Flags are computed from the next state so that the registered
  // copies line up with the state register.
  always_comb begin
    busyNext     = 1'b0;
    doneNext     = 1'b0;
    loadProduct  = 1'b0;
    clearProduct = 1'b0;
    busyNext     = (nextState == RUN);
    doneNext     = (nextState == DONE);
    loadProduct  = (state == RUN) && lastStep;
    clearProduct = accept && zeroOp;
  end

  // Operand, accumulator, counter and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aReg    <= '0;
      bReg    <= '0;
      acc     <= '0;
      stepCnt <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= busyNext;
      done <= doneNext;
      if (accept) begin
        aReg    <= A;
        bReg    <= B;
        acc     <= '0;
        stepCnt <= '0;
      end else if (state == RUN) begin
        acc     <= accNext;
        stepCnt <= stepCnt + CNT_W'(1);
      end
      if (clearProduct)     product <= '0;
      else if (loadProduct) product <= accNext;
    end
  end

endmodule : mult_sequencer
